// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b, LSB first.
// One full-subtractor cell and a borrow flop handle one bit per clock.
//
// Optional feature macro: SERIAL_SUB_OVF_EN (adds the signed overflow output ovf).
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - operation request, sampled only in IDLE
//   a, b  - minuend / subtrahend, captured on the accepting edge
//   busy  - high while bits are being processed (SHIFT)
//   done  - one-cycle pulse; diff/bout (and ovf) valid from this cycle on
//   diff  - (a - b) mod 2^WIDTH
//   bout  - final borrow, 1 iff a < b (unsigned)
//   ovf   - signed two's-complement overflow (only with SERIAL_SUB_OVF_EN)
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs.
  logic a0, b0, d_bit, br_next, last_bit;

  assign a0       = a_q[0];
  assign b0       = b_q[0];
  assign d_bit    = a0 ^ b0 ^ br_q;
  assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  assign last_bit = (cnt_q == LastCnt);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs depend only on flops, so no input reaches an output combinationally.
  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
    diff = res_q;
    bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf  = ovf_q;
`endif
  end

  // Datapath next-state.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    cnt_d  = cnt_q;
    br_d   = br_q;
    bout_d = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d  = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          br_d  = 1'b0;
          cnt_d = '0;
        end
      end
      StShift: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {d_bit, res_q[WIDTH-1:1]};
        br_d  = br_next;
        if (last_bit) begin
          cnt_d  = '0;
          bout_d = br_next;
`ifdef SERIAL_SUB_OVF_EN
          // On the final bit a0/b0 are the operand sign bits and d_bit the result sign.
          ovf_d  = (a0 != b0) && (d_bit != a0);
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      bout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      br_q   <= br_d;
      bout_q <= bout_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with a result scoreboard.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t sbq[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Starts an operation, optionally pokes start/a/b while busy, then checks the result.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit inject);
    exp_t e, got;
    logic [W-1:0] dref;
    int busy_cnt = 0;
    int cyc      = 0;
    int done_cnt = 0;
    dref   = av - bv;
    e.diff = dref;
    e.bout = (av < bv);
    e.ovf  = (av[W-1] != bv[W-1]) && (dref[W-1] != av[W-1]);
    sbq.push_back(e);
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && cyc < 30) begin
      if (busy) busy_cnt++;
      if (inject && cyc == 2) begin
        start = 1'b1; a = 8'h01; b = 8'h01;
      end else if (inject && cyc == 3) begin
        start = 1'b0; a = 8'hC3; b = 8'h7E;
      end
      tick();
      cyc++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", cyc, 32'd8);
    check("busy_cycles", busy_cnt, 32'd8);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    if (done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        check("sb_nonempty", 32'd0, 32'd1);
      end else begin
        got = sbq.pop_front();
        check("diff", {24'd0, diff}, {24'd0, got.diff});
        check("bout", {31'd0, bout}, {31'd0, got.bout});
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, got.ovf});
`endif
        // Results must hold after the pulse; done must drop.
        for (int i = 0; i < 3; i++) begin
          tick();
          if (done) done_cnt++;
        end
        check("diff_hold", {24'd0, diff}, {24'd0, got.diff});
        check("bout_hold", {31'd0, bout}, {31'd0, got.bout});
        check("busy_idle", {31'd0, busy}, 32'd0);
      end
    end
    check("done_pulses", done_cnt, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    tick();

    run_op(8'h5A, 8'h23, 1'b0);
    run_op(8'h10, 8'h20, 1'b0);
    run_op(8'h00, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0);
    run_op(8'h5A, 8'h23, 1'b1);
    check("sb_empty", sbq.size(), 32'd0);

    // Abort mid-operation; nothing is pushed to the scoreboard.
    a = 8'h10; b = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    begin
      int dseen = 0;
      for (int i = 0; i < 12; i++) begin
        if (done) dseen++;
        tick();
      end
      check("abort_no_done", dseen, 32'd0);
    end
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_diff", {24'd0, diff}, 32'd0);
    check("abort_bout", {31'd0, bout}, 32'd0);
    run_op(8'h09, 8'h04, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'h05, 8'h03, 1'b0);
`endif

    for (int k = 0; k < 4; k++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
